eth_udp_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 30 +++
 rtl/inet_csum_acc.sv | 41 ++++
 rtl/eth_udp_framer.sv | 208 ++++++++++++++++++++
 tb/tb_eth_udp_framer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants, FSM state encoding and checksum fold helper for the framer.
// Latency: n/a (package only).
// Backpressure: n/a.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  localparam int HDR_LEN      = 42;
  localparam int IP_HDR_OFS   = 14;
  localparam int UDP_HDR_OFS  = 34;
  localparam int IP_CSUM_OFS  = 24;
  localparam int UDP_CSUM_OFS = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HDR,
    S_PAYLOAD,
    S_FOLD,
    S_PATCH,
    S_START
  } state_e;

  // One end-around-carry step: low half plus everything above bit 15.
  function automatic logic [31:0] csum_fold(input logic [31:0] s);
    return {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
  endfunction

endpackage

// File: rtl/inet_csum_acc.sv
// Internet checksum accumulator: clear, add 16-bit words, fold, inverted result.
// Latency: add/fold take effect on the next clk; csum_o is combinational from the register.
// Backpressure: none; caller fully controls clr_i/add_i/fold_i.
//
// Ports: clk, rst_n (async, active-low); clr_i zeroes the sum; add_i adds word_i;
//        fold_i performs one carry fold (priority clr > fold > add); csum_o = ~sum[15:0].
module inet_csum_acc
  import eth_pkg::*;
#(
  parameter int W = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [15:0] word_i,
  input  logic        fold_i,
  output logic [15:0] csum_o
);

  logic [W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (fold_i) begin
      acc_d = W'(csum_fold(32'(acc_q)));
    end else if (add_i) begin
      acc_d = acc_q + W'(word_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign csum_o = ~acc_q[15:0];

endmodule

// File: rtl/eth_udp_framer.sv
// Builds one Ethernet/IPv4/UDP frame into the frame BRAM, patches checksums, then hands off via tx_start.
// Latency: header 42 clk, payload >= FRAME_LEN-42 clk, fold 2 + patch 2 (4 with UDP csum), then tx_start.
// Backpressure: pl_ready only in PAYLOAD; waits in WAIT while tx_busy so BRAM is never written under the transmitter.
//
// Ports: clk, rst_n; pl_data/pl_valid/pl_ready payload stream; tx_start level until tx_busy seen;
//        bram_wr_en/bram_wr_addr/bram_wr_data registered BRAM write port (addr/data hold when idle).
// Optional: define ETH_FRAMER_UDP_CSUM_EN to compute the UDP checksum (bytes 40-41) instead of sending 0.
module eth_udp_framer
  import eth_pkg::*;
#(
  parameter int          FRAME_LEN = 526,
  parameter logic [47:0] MAC_DST   = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] MAC_SRC   = 48'h020000000001,
  parameter logic [31:0] IP_SRC    = 32'hC0A80001,
  parameter logic [31:0] IP_DST    = 32'hC0A800FF,
  parameter logic [15:0] UDP_SPORT = 16'd4000,
  parameter logic [15:0] UDP_DPORT = 16'd4000,
  parameter logic [7:0]  TTL       = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       bram_wr_en,
  output logic [9:0] bram_wr_addr,
  output logic [7:0] bram_wr_data
);

  localparam logic [15:0] IP_LEN    = 16'(FRAME_LEN - IP_HDR_OFS);
  localparam logic [15:0] UDP_LEN   = 16'(FRAME_LEN - UDP_HDR_OFS);
  localparam logic [9:0]  LAST_ADDR = 10'(FRAME_LEN - 1);
`ifdef ETH_FRAMER_UDP_CSUM_EN
  localparam logic [1:0]  PATCH_LAST = 2'd3;
`else
  localparam logic [1:0]  PATCH_LAST = 2'd1;
`endif

  // Header template, byte 0 in the MSBs. Ident and both checksums are zero here;
  // ident is substituted at write time, checksums are patched afterwards.
  localparam logic [8*HDR_LEN-1:0] HDR_CONST = {
    MAC_DST, MAC_SRC, ETHERTYPE_IPV4,
    8'h45, 8'h00, IP_LEN, 16'h0000, 16'h4000, TTL, IP_PROTO_UDP, 16'h0000, IP_SRC, IP_DST,
    UDP_SPORT, UDP_DPORT, UDP_LEN, 16'h0000
  };

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [1:0]  sub_q, sub_d;
  logic [15:0] ident_q, ident_d;
  logic        tx_start_q, tx_start_d;
  logic        wr_en_q, wr_en_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [5:0]  hdr_idx;
  logic [7:0]  hdr_b;
  logic        acc_clr, acc_fold, ip_add;
  logic [15:0] ip_word, ip_csum;

  assign hdr_idx = 6'(HDR_LEN - 1) - cnt_q[5:0];

  always_comb begin
    hdr_b = HDR_CONST[{hdr_idx, 3'b000} +: 8];
    if (cnt_q[5:0] == 6'(IP_HDR_OFS + 4))      hdr_b = ident_q[15:8];
    else if (cnt_q[5:0] == 6'(IP_HDR_OFS + 5)) hdr_b = ident_q[7:0];
  end

  // wr_data_q still holds the byte written at cnt_q-1, i.e. the high byte of the word.
  assign ip_word = {wr_data_q, hdr_b};

  inet_csum_acc #(.W(20)) u_ip_csum (
    .clk(clk), .rst_n(rst_n), .clr_i(acc_clr), .add_i(ip_add),
    .word_i(ip_word), .fold_i(acc_fold), .csum_o(ip_csum)
  );

`ifdef ETH_FRAMER_UDP_CSUM_EN
  logic        udp_add;
  logic [15:0] udp_word, udp_csum, udp_tx;

  inet_csum_acc #(.W(32)) u_udp_csum (
    .clk(clk), .rst_n(rst_n), .clr_i(acc_clr), .add_i(udp_add),
    .word_i(udp_word), .fold_i(acc_fold), .csum_o(udp_csum)
  );

  assign udp_tx = (udp_csum == 16'h0000) ? 16'hFFFF : udp_csum;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    ident_d   = ident_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    acc_clr   = 1'b0;
    acc_fold  = 1'b0;
    ip_add    = 1'b0;
`ifdef ETH_FRAMER_UDP_CSUM_EN
    udp_add   = 1'b0;
    udp_word  = ip_word;
`endif
    case (state_q)
      S_IDLE: if (pl_valid) state_d = S_WAIT;
      S_WAIT: if (!tx_busy) begin
        state_d = S_HDR;
        cnt_d   = '0;
        acc_clr = 1'b1;
      end
      S_HDR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = hdr_b;
        cnt_d     = cnt_q + 10'd1;
        if (cnt_q[0] && cnt_q >= 10'(IP_HDR_OFS + 1) && cnt_q <= 10'(UDP_HDR_OFS - 1)) ip_add = 1'b1;
`ifdef ETH_FRAMER_UDP_CSUM_EN
        // Odd addresses 25..41: IP addresses and UDP header come from the stream; the two
        // zero checksum words are replaced by the pseudo-header length and protocol.
        if (cnt_q[0] && cnt_q >= 10'(IP_CSUM_OFS + 1)) begin
          udp_add = 1'b1;
          if (cnt_q == 10'(IP_CSUM_OFS + 1))       udp_word = UDP_LEN;
          else if (cnt_q == 10'(UDP_CSUM_OFS + 1)) udp_word = {8'h00, IP_PROTO_UDP};
        end
`endif
        if (cnt_q == 10'(HDR_LEN - 1)) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: if (pl_valid) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = pl_data;
        cnt_d     = cnt_q + 10'd1;
`ifdef ETH_FRAMER_UDP_CSUM_EN
        if (cnt_q[0]) begin
          udp_add  = 1'b1;
          udp_word = {wr_data_q, pl_data};
        end else if (cnt_q == LAST_ADDR) begin
          udp_add  = 1'b1;
          udp_word = {pl_data, 8'h00};
        end
`endif
        if (cnt_q == LAST_ADDR) begin
          state_d = S_FOLD;
          sub_d   = 2'd0;
        end
      end
      S_FOLD: begin
        acc_fold = 1'b1;
        sub_d    = sub_q + 2'd1;
        if (sub_q == 2'd1) begin
          state_d = S_PATCH;
          sub_d   = 2'd0;
        end
      end
      S_PATCH: begin
        wr_en_d = 1'b1;
        case (sub_q)
          2'd0: begin wr_addr_d = 10'(IP_CSUM_OFS);      wr_data_d = ip_csum[15:8]; end
          2'd1: begin wr_addr_d = 10'(IP_CSUM_OFS + 1);  wr_data_d = ip_csum[7:0];  end
`ifdef ETH_FRAMER_UDP_CSUM_EN
          2'd2: begin wr_addr_d = 10'(UDP_CSUM_OFS);     wr_data_d = udp_tx[15:8];  end
          2'd3: begin wr_addr_d = 10'(UDP_CSUM_OFS + 1); wr_data_d = udp_tx[7:0];   end
`endif
          default: ;
        endcase
        if (sub_q == PATCH_LAST) state_d = S_START;
        else                     sub_d   = sub_q + 2'd1;
      end
      S_START: if (tx_busy) begin
        state_d = S_IDLE;
        ident_d = ident_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    tx_start_d = (state_d == S_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sub_q      <= '0;
      ident_q    <= '0;
      tx_start_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      ident_q    <= ident_d;
      tx_start_q <= tx_start_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign pl_ready     = (state_q == S_PAYLOAD);
  assign tx_start     = tx_start_q;
  assign bram_wr_en   = wr_en_q;
  assign bram_wr_addr = wr_addr_q;
  assign bram_wr_data = wr_data_q;

endmodule

// File: tb/tb_eth_udp_framer.sv
// Directed bench for eth_udp_framer with FRAME_LEN=129, IP_DST=C0A800C7.
// A negedge monitor captures every BRAM write into a shadow memory and an address log.
// Scenario tasks run in sequence; each compares against hand-derived header bytes.
module tb_eth_udp_framer;

  localparam int FL = 129;
`ifdef ETH_FRAMER_UDP_CSUM_EN
  localparam int N_PATCH = 4;
`else
  localparam int N_PATCH = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       tx_start;
  logic       tx_busy;
  logic       bram_wr_en;
  logic [9:0] bram_wr_addr;
  logic [7:0] bram_wr_data;

  int errs;
  int checks;
  int cyc;
  int busy_wr;
  int hdr_cyc;
  logic [7:0] mem [0:1023];
  logic [7:0] pay [0:1023];
  int log_q [$];

  eth_udp_framer #(.FRAME_LEN(FL), .IP_DST(32'hC0A800C7)) dut (
    .clk(clk), .rst_n(rst_n),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .tx_start(tx_start), .tx_busy(tx_busy),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_wr_en) begin
      mem[bram_wr_addr] <= bram_wr_data;
      log_q.push_back(int'(bram_wr_addr));
      if (tx_busy) busy_wr <= busy_wr + 1;
      if (bram_wr_addr == 10'd0) hdr_cyc <= cyc;
    end
  end

  function automatic logic [15:0] exp_udp();
`ifdef ETH_FRAMER_UDP_CSUM_EN
    logic [31:0] s;
    logic [15:0] r;
    s = 32'hC0A8 + 32'h0001 + 32'hC0A8 + 32'h00C7 + 32'h0011 + 32'd95
      + 32'h0FA0 + 32'h0FA0 + 32'd95;
    for (int i = 0; i < FL - 42; i += 2)
      s = s + {16'h0000, pay[i], (i + 1 < FL - 42) ? pay[i+1] : 8'h00};
    while (s[31:16] != 16'h0000) s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
    r = ~s[15:0];
    return (r == 16'h0000) ? 16'hFFFF : r;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_frame(input string tag, input logic [15:0] id, input logic [15:0] ipc,
                             input logic [15:0] udpc);
    logic [7:0] eh [0:41];
    logic [7:0] e;
    int ea;
    eh = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
           8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
           8'h08, 8'h00,
           8'h45, 8'h00, 8'h00, 8'h73, id[15:8], id[7:0],
           8'h40, 8'h00, 8'h40, 8'h11, ipc[15:8], ipc[7:0],
           8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7,
           8'h0F, 8'hA0, 8'h0F, 8'hA0, 8'h00, 8'h5F, udpc[15:8], udpc[7:0]};
    for (int i = 0; i < FL; i++) begin
      e = (i < 42) ? eh[i] : pay[i-42];
      checks++;
      if (mem[i] !== e) begin
        errs++;
        $display("FAIL %s byte[%0d]: got %h expected %h", tag, i, mem[i], e);
      end
    end
    checks++;
    if (log_q.size() != FL + N_PATCH) begin
      errs++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, log_q.size(), FL + N_PATCH);
    end
    for (int i = 0; i < log_q.size() && i < FL + N_PATCH; i++) begin
      ea = (i < FL) ? i : ((i - FL < 2) ? 24 + (i - FL) : 38 + (i - FL));
      checks++;
      if (log_q[i] != ea) begin
        errs++;
        $display("FAIL %s write_addr[%0d]: got %0d expected %0d", tag, i, log_q[i], ea);
      end
    end
  endtask

  // Drives n payload bytes from pay[], optionally with random pl_valid gaps.
  task automatic feed(input string tag, input int n, input bit rnd, input bit chk_end);
    int  idx;
    int  g;
    bit  v;
    bit  rdy;
    idx = 0; g = 0; v = 1'b0; rdy = 1'b0;
    while (idx < n && g < 4000) begin
      @(negedge clk);
      g++;
      if (v && rdy) idx++;
      if (idx < n) begin
        v        = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        pl_valid = v;
        pl_data  = pay[idx];
        rdy      = pl_ready;
      end
    end
    pl_valid = 1'b0;
    checks++;
    if (idx != n) begin
      errs++;
      $display("FAIL %s feed_timeout: got %0d bytes expected %0d", tag, idx, n);
    end
    if (chk_end) begin
      checks++;
      if (pl_ready !== 1'b0) begin
        errs++;
        $display("FAIL %s pl_ready_after_last: got %b expected 0", tag, pl_ready);
      end
    end
  endtask

  // Transmitter stand-in: waits for tx_start, raises tx_busy, checks the drop.
  task automatic tx_handshake(input string tag, input bit nxt_valid, input logic [7:0] nxt_data);
    int g;
    g = 0;
    while (tx_start !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (tx_start !== 1'b1) begin
      errs++;
      $display("FAIL %s tx_start_rise: got %b expected 1 within 500 cycles", tag, tx_start);
    end else begin
      checks++;
      if (cyc - hdr_cyc + 1 < FL + 4) begin
        errs++;
        $display("FAIL %s latency: got %0d expected >= %0d", tag, cyc - hdr_cyc + 1, FL + 4);
      end
      @(negedge clk);
      checks++;
      if (tx_start !== 1'b1) begin
        errs++;
        $display("FAIL %s tx_start_hold: got %b expected 1", tag, tx_start);
      end
      tx_busy = 1'b1;
      if (nxt_valid) begin
        pl_valid = 1'b1;
        pl_data  = nxt_data;
      end
      @(negedge clk);
      checks++;
      if (tx_start !== 1'b0) begin
        errs++;
        $display("FAIL %s tx_start_drop: got %b expected 0", tag, tx_start);
      end
      repeat (6) @(negedge clk);
      tx_busy = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (tx_start !== 1'b0 || pl_ready !== 1'b0 || bram_wr_en !== 1'b0 ||
        bram_wr_addr !== 10'd0 || bram_wr_data !== 8'd0) begin
      errs++;
      $display("FAIL %s outputs: got start=%b rdy=%b wen=%b addr=%h data=%h expected all 0",
               tag, tx_start, pl_ready, bram_wr_en, bram_wr_addr, bram_wr_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pl_valid = 1'b0; pl_data = 8'h00; tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_frame();
    for (int i = 0; i < FL - 42; i++) pay[i] = 8'(i);
    log_q.delete();
    feed("frame1", FL - 42, 1'b0, 1'b1);
    tx_handshake("frame1", 1'b1, 8'h07);
    check_frame("frame1", 16'h0000, 16'hB861, exp_udp());
    log_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < FL - 42; i++) pay[i] = 8'(i * 3 + 7);
    feed("frame2", FL - 42, 1'b0, 1'b1);
    tx_handshake("frame2", 1'b0, 8'h00);
    check_frame("frame2", 16'h0001, 16'hB860, exp_udp());
    checks++;
    if (busy_wr != 0) begin
      errs++;
      $display("FAIL b2b busy_writes: got %0d expected 0", busy_wr);
    end
  endtask

  task automatic test_wait_hold();
    for (int i = 0; i < FL - 42; i++) pay[i] = 8'(i) ^ 8'hA5;
    log_q.delete();
    tx_busy  = 1'b1;
    pl_valid = 1'b1;
    pl_data  = pay[0];
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (bram_wr_en !== 1'b0 || pl_ready !== 1'b0) begin
        errs++;
        $display("FAIL wait_hold: got wen=%b rdy=%b expected 0 0", bram_wr_en, pl_ready);
      end
    end
    tx_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (bram_wr_en !== 1'b0) begin
      errs++;
      $display("FAIL wait_release_early: got wen=%b expected 0", bram_wr_en);
    end
    @(negedge clk);
    checks++;
    if (bram_wr_en !== 1'b1 || bram_wr_addr !== 10'd0) begin
      errs++;
      $display("FAIL hdr_start: got wen=%b addr=%0d expected 1 0", bram_wr_en, bram_wr_addr);
    end
    feed("frame3", FL - 42, 1'b1, 1'b1);
    tx_handshake("frame3", 1'b0, 8'h00);
    check_frame("frame3", 16'h0002, 16'hB85F, exp_udp());
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < FL - 42; i++) pay[i] = 8'(200 - i);
    log_q.delete();
    feed("partial", 30, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    feed("frame_after_rst", FL - 42, 1'b0, 1'b1);
    tx_handshake("frame_after_rst", 1'b0, 8'h00);
    check_frame("frame_after_rst", 16'h0000, 16'hB861, exp_udp());
  endtask

`ifdef ETH_FRAMER_UDP_CSUM_EN
  task automatic test_udp_csum();
    for (int i = 0; i < FL - 42; i++) pay[i] = 8'h00;
    log_q.delete();
    feed("udp_zero", FL - 42, 1'b0, 1'b1);
    tx_handshake("udp_zero", 1'b0, 8'h00);
    check_frame("udp_zero", 16'h0001, 16'hB860, 16'h5DD7);
    pay[0] = 8'h5D;
    pay[1] = 8'hD7;
    log_q.delete();
    feed("udp_ffff", FL - 42, 1'b0, 1'b1);
    tx_handshake("udp_ffff", 1'b0, 8'h00);
    check_frame("udp_ffff", 16'h0002, 16'hB85F, 16'hFFFF);
  endtask
`endif

  initial begin
    errs   = 0;
    checks = 0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_wait_hold();
    test_reset_mid();
`ifdef ETH_FRAMER_UDP_CSUM_EN
    test_udp_csum();
`endif
    checks++;
    if (busy_wr != 0) begin
      errs++;
      $display("FAIL busy_writes_total: got %0d expected 0", busy_wr);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
